// File: rtl/round_robin_grant_scheduler.sv
// Round-robin grant scheduler with hold limit and registered grant outputs.
// Define ROUND_ROBIN_LOCK_EN to add the lock input that blocks hold-limit preemption.
module round_robin_grant_scheduler #(
  parameter int REQ_COUNT   = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int HOLD_MAX    = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [REQ_COUNT-1:0]   req,
  input  logic                   done,
`ifdef ROUND_ROBIN_LOCK_EN
  input  logic                   lock,
`endif
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic [REQ_COUNT-1:0]   grant_onehot
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [REQ_COUNT-1:0]   r_onehot;
  logic [CW-1:0]          r_cnt;
  logic [INDEX_WIDTH-1:0] r_last;

  logic                   w_lock;
  logic                   w_held;
  logic                   w_others;
  logic                   w_yield;
  logic                   w_release;
  logic [INDEX_WIDTH-1:0] w_base;
  logic [REQ_COUNT-1:0]   w_cand;
  logic                   w_found;
  logic [INDEX_WIDTH-1:0] w_win;
  logic [REQ_COUNT-1:0]   w_win_oh;

`ifdef ROUND_ROBIN_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_held    = |(req & r_onehot);
  assign w_others  = |(req & ~r_onehot);
  assign w_yield   = done | ~w_held;
  assign w_release = w_yield
                   | ((r_cnt == CMAX) & w_others & ~w_lock);

  assign w_base = (r_state == GRANTED) ? r_idx : r_last;
  // A yielding holder may not re-win; a preempted one stays last in line.
  assign w_cand = (r_state == GRANTED && w_yield)
                ? (req & ~r_onehot) : req;

  always_comb begin
    int j;
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    j        = 0;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      j = (int'(w_base) + k) % REQ_COUNT;
      if (w_cand[j]) begin
        w_found     = 1'b1;
        w_win       = INDEX_WIDTH'(j);
        w_win_oh    = '0;
        w_win_oh[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_cnt    <= '0;
      r_last   <= INDEX_WIDTH'(REQ_COUNT - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= GRANTED;
            r_valid  <= 1'b1;
            r_idx    <= w_win;
            r_onehot <= w_win_oh;
            r_cnt    <= '0;
          end
        end
        GRANTED: begin
          if (w_release) begin
            r_last <= r_idx;
            if (w_found) begin
              r_idx    <= w_win;
              r_onehot <= w_win_oh;
              r_cnt    <= '0;
            end else begin
              r_state  <= IDLE;
              r_valid  <= 1'b0;
              r_idx    <= '0;
              r_onehot <= '0;
              r_cnt    <= '0;
            end
          end else if (r_cnt != CMAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign grant_valid  = r_valid;
  assign grant_index  = r_idx;
  assign grant_onehot = r_onehot;

endmodule
